avmm_cmd_master: RTL and testbench

Avalon-MM master that issues the register writes and reads which program the stepper-command register block (TR_MANUAL/TR_AUTO/TX/TP parameters and control word). It accepts single-beat commands on a valid/ready stream from a host-side source (UART/SPI bridge or sequencer) and runs one bus transfer at a time. It handles waitrequest stretching and fixed read latency, and returns read data on a valid/ready response stream. A timeout guards against a hung slave.

---
 rtl/avmm_cmd_pkg.sv | 36 +++
 rtl/avmm_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_avmm_cmd_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_cmd_pkg.sv
// Shared definitions for the stepper-command Avalon-MM master.
//   state_e          : master FSM states
//   Reg*             : register-map word addresses of the command register block
//   Ctrl*            : bit positions inside the control word (RegCtrl)
package avmm_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait
    } state_e;

    // Register map of the command block. Multi-word parameters are split low-to-high.
    localparam logic [3:0] RegCtrl       = 4'h0;
    localparam logic [3:0] RegStatus     = 4'h1;
    localparam logic [3:0] RegTrManual0  = 4'h2;
    localparam logic [3:0] RegTrManual1  = 4'h3;
    localparam logic [3:0] RegTrManual2  = 4'h4;
    localparam logic [3:0] RegTrAuto0    = 4'h5;
    localparam logic [3:0] RegTrAuto1    = 4'h6;
    localparam logic [3:0] RegTrAuto2    = 4'h7;
    localparam logic [3:0] RegTx0        = 4'h8;
    localparam logic [3:0] RegTx1        = 4'h9;
    localparam logic [3:0] RegTx2        = 4'hA;
    localparam logic [3:0] RegTp0        = 4'hB;
    localparam logic [3:0] RegTp1        = 4'hC;
    localparam logic [3:0] RegTp2        = 4'hD;
    localparam logic [3:0] RegStepCount  = 4'hE;

    // Control word bit positions.
    localparam int unsigned CtrlStop   = 0;
    localparam int unsigned CtrlStart  = 1;
    localparam int unsigned CtrlStartN = 2;

endpackage

// File: rtl/avmm_cmd_master.sv
// Avalon-MM master that turns single-beat host commands into register writes/reads on the
// stepper-command register block, one bus transfer at a time.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_*               : command stream in (valid/ready), write flag, address, write data
//   rsp_*               : read response stream out (valid/ready), data, timeout-abort flag
//   wr_timeout          : one-cycle pulse when a write is aborted by the timeout
//   busy                : a transfer is in flight
//   txn_count           : completed (non-aborted) transfers, wrapping
//   avm_m0_*            : Avalon-MM master port
// RD_LATENCY must be in 1..7; TIMEOUT = 0 disables the hung-slave abort.
module avmm_cmd_master
    import avmm_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,

    output logic              wr_timeout,
    output logic              busy,
    output logic [15:0]       txn_count,

    output logic [ADDR_W-1:0] avm_m0_address,
    output logic [DATA_W-1:0] avm_m0_writedata,
    output logic              avm_m0_write,
    output logic              avm_m0_read,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_waitrequest
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned LatW  = 3;
    localparam bit          TimeoutEn = (TIMEOUT != 0);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                read_q, read_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [WaitW-1:0]    wait_inc;
    logic                timeout_hit;
    logic [LatW-1:0]     lat_q, lat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                wr_timeout_q, wr_timeout_d;
    logic [15:0]         txn_q, txn_d;

    // The stall cycle being evaluated is counted before comparing, so the request is held
    // for exactly TIMEOUT stalled cycles.
    assign wait_inc    = wait_q + WaitW'(1);
    assign timeout_hit = TimeoutEn && (wait_inc == WaitW'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = 1'b0;
        read_d        = 1'b0;
        wait_d        = wait_q;
        lat_d         = lat_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        wr_timeout_d  = 1'b0;
        txn_d         = txn_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d   = 1'b0;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wait_d  = '0;
                    if (cmd_write) begin
                        state_d = StWr;
                        write_d = 1'b1;
                    end else begin
                        state_d = StRd;
                        read_d  = 1'b1;
                    end
                end
            end
            StWr: begin
                if (!avm_m0_waitrequest) begin
                    txn_d   = txn_q + 16'd1;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    wr_timeout_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    write_d = 1'b1;
                    wait_d  = wait_inc;
                end
            end
            StRd: begin
                if (!avm_m0_waitrequest) begin
                    lat_d   = LatW'(RD_LATENCY);
                    state_d = StRdWait;
                end else if (timeout_hit) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = StIdle;
                end else begin
                    read_d = 1'b1;
                    wait_d = wait_inc;
                end
            end
            StRdWait: begin
                // lat_q == 1 marks the cycle RD_LATENCY after the read was accepted.
                if (lat_q == LatW'(1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = avm_m0_readdata;
                    txn_d         = txn_q + 16'd1;
                    state_d       = StIdle;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered ready: a pending response blocks the next command.
        cmd_ready_d = (state_d == StIdle) && !rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            wait_q        <= '0;
            lat_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            wr_timeout_q  <= 1'b0;
            txn_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            read_q        <= read_d;
            wait_q        <= wait_d;
            lat_q         <= lat_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            wr_timeout_q  <= wr_timeout_d;
            txn_q         <= txn_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign wr_timeout       = wr_timeout_q;
    assign busy             = (state_q != StIdle);
    assign txn_count        = txn_q;
    assign avm_m0_address   = addr_q;
    assign avm_m0_writedata = wdata_q;
    assign avm_m0_write     = write_q;
    assign avm_m0_read      = read_q;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Self-checking bench for avmm_cmd_master: a behavioural Avalon slave with programmable
// stall / stuck waitrequest, a scoreboard of expected read responses, and directed
// cycle-accurate checks plus a short random command mix.
module tb_avmm_cmd_master;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned TIMEOUT    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              wr_timeout;
    logic              busy;
    logic [15:0]       txn_count;
    logic [ADDR_W-1:0] avm_m0_address;
    logic [DATA_W-1:0] avm_m0_writedata;
    logic              avm_m0_write;
    logic              avm_m0_read;
    logic [DATA_W-1:0] avm_m0_readdata;
    logic              avm_m0_waitrequest;

    always #10 clk = ~clk;

    avmm_cmd_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_timeout        (rsp_timeout),
        .wr_timeout         (wr_timeout),
        .busy               (busy),
        .txn_count          (txn_count),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_read        (avm_m0_read),
        .avm_m0_readdata    (avm_m0_readdata),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic        stuck = 1'b0;
    int unsigned stall_len = 0;
    int unsigned stall_seen = 0;
    logic [31:0] slv_mem [16];
    logic [31:0] rd_pipe = '0;
    logic        rd_pipe_v = 1'b0;
    logic        req;

    assign req                = avm_m0_write | avm_m0_read;
    assign avm_m0_waitrequest = stuck | (req && (stall_seen < stall_len));
    // Garbage outside the one valid cycle exposes sampling at the wrong latency.
    assign avm_m0_readdata    = rd_pipe_v ? rd_pipe : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (req && avm_m0_waitrequest) stall_seen <= stall_seen + 1;
        else if (!req)                 stall_seen <= 0;
        rd_pipe_v <= avm_m0_read && !avm_m0_waitrequest;
        if (avm_m0_read && !avm_m0_waitrequest) rd_pipe <= slv_mem[avm_m0_address[3:0]];
        if (rst) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
        end else if (avm_m0_write && !avm_m0_waitrequest) begin
            slv_mem[avm_m0_address[3:0]] <= avm_m0_writedata;
        end
    end

    // ---------------- scoreboard + protocol monitor ----------------
    typedef struct packed {
        logic        to;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model_mem [16];
    logic [15:0] exp_txn = '0;
    logic [15:0] prev_addr = '0;
    logic        prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rw_exclusive", avm_m0_write & avm_m0_read, 1'b0);
            if (prev_stall && req) check("addr_stable", avm_m0_address, prev_addr);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_rsp_timeout", rsp_timeout, e.to);
                    check("sb_rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
        prev_stall <= !rst && req && avm_m0_waitrequest;
        prev_addr  <= avm_m0_address;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 into the cycle after the accepting edge (first request cycle).
    task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d);
        int unsigned n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_accept_bound", 1'b0, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_read(input logic [3:0] a);
        exp_t e;
        e.to    = 1'b0;
        e.rdata = model_mem[a];
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((busy || rsp_valid || !cmd_ready) && n < 200) begin
            tick();
            n++;
        end
        if (busy || rsp_valid || !cmd_ready) check("idle_bound", 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic [31:0] held;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_write", avm_m0_write, 1'b0);
        check("rst_read", avm_m0_read, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_txn", txn_count, 16'd0);
        check("rst_addr", avm_m0_address, 16'd0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write
        send_cmd(1'b1, 16'h5, 32'h0000_1234);
        model_mem[5] = 32'h0000_1234;
        exp_txn++;
        check("wr_req", avm_m0_write, 1'b1);
        check("wr_no_rd", avm_m0_read, 1'b0);
        check("wr_addr", avm_m0_address, 16'h5);
        check("wr_data", avm_m0_writedata, 32'h0000_1234);
        check("wr_busy", busy, 1'b1);
        check("wr_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        check("wr_drop", avm_m0_write, 1'b0);
        check("wr_cmd_ready_n2", cmd_ready, 1'b1);
        check("wr_txn", txn_count, exp_txn);

        // Zero-wait read, latency 1
        push_read(4'h5);
        send_cmd(1'b0, 16'h5, 32'h0);
        exp_txn++;
        check("rd_req", avm_m0_read, 1'b1);
        check("rd_addr", avm_m0_address, 16'h5);
        tick();
        check("rd_drop", avm_m0_read, 1'b0);
        check("rd_rsp_early", rsp_valid, 1'b0);
        tick();
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
        check("rd_rsp_timeout", rsp_timeout, 1'b0);
        check("rd_txn", txn_count, exp_txn);
        tick();
        check("rd_rsp_clear", rsp_valid, 1'b0);

        // Read with three stall cycles
        send_cmd(1'b1, 16'h6, 32'hCAFE_0006);
        model_mem[6] = 32'hCAFE_0006;
        exp_txn++;
        wait_idle();
        stall_len = 3;
        push_read(4'h6);
        send_cmd(1'b0, 16'h6, 32'h0);
        exp_txn++;
        for (int i = 0; i < 4; i++) begin
            check("stall_rd_held", avm_m0_read, 1'b1);
            check("stall_rd_addr", avm_m0_address, 16'h6);
            tick();
        end
        check("stall_rd_drop", avm_m0_read, 1'b0);
        tick();
        check("stall_rsp_valid", rsp_valid, 1'b1);
        check("stall_rsp_rdata", rsp_rdata, 32'hCAFE_0006);
        stall_len = 0;
        wait_idle();
        check("stall_txn", txn_count, exp_txn);

        // Read timeout
        stuck = 1'b1;
        sb_q.push_back('{to: 1'b1, rdata: 32'h0});
        send_cmd(1'b0, 16'h7, 32'h0);
        n = 0;
        while (avm_m0_read && n < 20) begin
            n++;
            tick();
        end
        check("to_rd_cycles", n, TIMEOUT);
        check("to_rd_rsp_valid", rsp_valid, 1'b1);
        check("to_rd_rsp_timeout", rsp_timeout, 1'b1);
        check("to_rd_rsp_rdata", rsp_rdata, 32'h0);
        stuck = 1'b0;
        wait_idle();
        check("to_rd_txn", txn_count, exp_txn);

        // Write timeout
        stuck = 1'b1;
        send_cmd(1'b1, 16'h8, 32'hFFFF_0008);
        n = 0;
        while (avm_m0_write && n < 20) begin
            n++;
            tick();
        end
        check("to_wr_cycles", n, TIMEOUT);
        check("to_wr_pulse", wr_timeout, 1'b1);
        tick();
        check("to_wr_pulse_end", wr_timeout, 1'b0);
        stuck = 1'b0;
        wait_idle();
        check("to_wr_txn", txn_count, exp_txn);

        // Response back-pressure blocks the next command
        rsp_ready = 1'b0;
        push_read(4'h5);
        send_cmd(1'b0, 16'h5, 32'h0);
        exp_txn++;
        n = 0;
        while (!rsp_valid && n < 20) begin
            n++;
            tick();
        end
        check("bp_rsp_valid", rsp_valid, 1'b1);
        held = rsp_rdata;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h9; cmd_wdata = 32'h0000_9999;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_cmd_ready", cmd_ready, 1'b0);
            check("bp_rsp_hold", rsp_valid, 1'b1);
            check("bp_rdata_stable", rsp_rdata, held);
            check("bp_no_write", avm_m0_write, 1'b0);
        end
        rsp_ready = 1'b1;
        send_cmd(1'b1, 16'h9, 32'h0000_9999);
        model_mem[9] = 32'h0000_9999;
        exp_txn++;
        check("bp_rsp_done", rsp_valid, 1'b0);
        check("bp_sb_empty", sb_q.size(), 0);
        check("bp_wr_req", avm_m0_write, 1'b1);
        check("bp_wr_addr", avm_m0_address, 16'h9);
        wait_idle();

        // Random mix with random stalls
        for (int k = 0; k < 10; k++) begin
            logic [3:0]  a;
            logic [31:0] d;
            logic        wr;
            a  = 4'($urandom_range(0, 14));
            d  = $urandom;
            wr = 1'($urandom_range(0, 1));
            stall_len = $urandom_range(0, 3);
            if (wr) model_mem[a] = d;
            else    push_read(a);
            send_cmd(wr, {12'h0, a}, d);
            exp_txn++;
            wait_idle();
        end
        stall_len = 0;
        check("mix_txn", txn_count, exp_txn);
        check("mix_sb_empty", sb_q.size(), 0);

        // Reset in the cycle the read data would be captured
        send_cmd(1'b0, 16'h5, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_rsp_valid", rsp_valid, 1'b0);
        check("mrst_cmd_ready", cmd_ready, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_read", avm_m0_read, 1'b0);
        check("mrst_write", avm_m0_write, 1'b0);
        check("mrst_addr", avm_m0_address, 16'h0);
        check("mrst_wdata", avm_m0_writedata, 32'h0);
        check("mrst_rdata", rsp_rdata, 32'h0);
        check("mrst_rsp_timeout", rsp_timeout, 1'b0);
        check("mrst_wr_timeout", wr_timeout, 1'b0);
        check("mrst_txn", txn_count, 16'h0);
        rst = 1'b0;
        tick();
        check("mrst_cmd_ready_after", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_no_rsp", rsp_valid, 1'b0);
        end
        check("end_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
